// File: rtl/fifo_stream_out_if.sv
// Stream-side bundle of the FIFO drain stage: FIFO read port plus the
// valid/ready/last output stream.
interface fifo_stream_out_if #(
  parameter int DATA_W = 32
);
  logic              o_fifo_r_en;
  logic [DATA_W-1:0] in_fifo_data;
  logic              in_fifo_empty;
  logic [DATA_W-1:0] o_data;
  logic              o_valid;
  logic              in_ready;
  logic              o_last;

  modport master (
    output o_fifo_r_en,
    input  in_fifo_data,
    input  in_fifo_empty,
    output o_data,
    output o_valid,
    input  in_ready,
    output o_last
  );

  modport slave (
    input  o_fifo_r_en,
    output in_fifo_data,
    output in_fifo_empty,
    input  o_data,
    input  o_valid,
    output in_ready,
    input  o_last
  );
endinterface

// File: rtl/fifo_stream_out.sv
// Drain stage between the register-file FIFO read port and a framed
// valid/ready stream; a 2-entry buffer hides the FIFO's one-cycle read latency.
module fifo_stream_out #(
  parameter int DATA_W    = 32,
  parameter int FRAME_LEN = 4,
  parameter int CNT_W     = 16
) (
  input  logic             in_clk,
  input  logic             in_rst,
  input  logic             in_enable,
  fifo_stream_out_if.master s_if,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic             o_busy
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [IDX_W-1:0]  out_idx_q, out_idx_d;
  logic [1:0]        occ_q, occ_d;
  logic              pend_q, pend_d;
  logic              head_q, head_d;
  logic [DATA_W-1:0] buf_q [2];
  logic [CNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic              pop_s;
  logic              valid_s;
  logic              last_s;
  logic              rd_gate_s;
  logic              rd_en_s;
  logic              tail_s;
  logic [2:0]        commit_s;

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] idx);
    return (idx == IDX_LAST) ? {IDX_W{1'b0}} : idx + IDX_W'(1);
  endfunction

  // Handshake, occupancy budget and read-enable decode.
  always_comb begin
    valid_s  = (occ_q != 2'd0);
    pop_s    = valid_s & s_if.in_ready;
    last_s   = valid_s & (out_idx_q == IDX_LAST);
    commit_s = {1'b0, occ_q} + {2'b00, pend_q} - {2'b00, pop_s};
    // With in_enable low, a new frame is never started: reads continue only
    // while the current frame still owes words.
    rd_gate_s = (state_q != ST_IDLE) & (in_enable | (rd_idx_q != {IDX_W{1'b0}}));
    rd_en_s   = rd_gate_s & ~s_if.in_fifo_empty & (commit_s < 3'd2);
    tail_s    = head_q ^ occ_q[0];
  end

  // Counter, pointer and occupancy next-state.
  always_comb begin
    rd_idx_d    = rd_idx_q;
    out_idx_d   = out_idx_q;
    frame_cnt_d = frame_cnt_q;
    head_d      = head_q;
    occ_d       = commit_s[1:0];
    pend_d      = rd_en_s;
    if (rd_en_s) begin
      rd_idx_d = idx_inc(rd_idx_q);
    end else begin
      rd_idx_d = rd_idx_q;
    end
    if (pop_s) begin
      out_idx_d = idx_inc(out_idx_q);
      head_d    = ~head_q;
    end else begin
      out_idx_d = out_idx_q;
      head_d    = head_q;
    end
    if (pop_s & last_s) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end else begin
      frame_cnt_d = frame_cnt_q;
    end
  end

  // Run/stop FSM next-state; leaving RUN/STOP only happens on a frame boundary.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (in_enable) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN, ST_STOP: begin
        if (in_enable) begin
          state_d = ST_RUN;
        end else if (rd_idx_d == {IDX_W{1'b0}}) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      state_q     <= ST_IDLE;
      rd_idx_q    <= {IDX_W{1'b0}};
      out_idx_q   <= {IDX_W{1'b0}};
      occ_q       <= 2'd0;
      pend_q      <= 1'b0;
      head_q      <= 1'b0;
      frame_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      rd_idx_q    <= rd_idx_d;
      out_idx_q   <= out_idx_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      head_q      <= head_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Output buffer storage; the word read last cycle lands at the tail.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      buf_q[0] <= {DATA_W{1'b0}};
      buf_q[1] <= {DATA_W{1'b0}};
    end else if (pend_q) begin
      buf_q[tail_s] <= s_if.in_fifo_data;
    end
  end

  assign s_if.o_fifo_r_en = rd_en_s;
  assign s_if.o_data      = buf_q[head_q];
  assign s_if.o_valid     = valid_s;
  assign s_if.o_last      = last_s;
  assign o_frame_cnt      = frame_cnt_q;
  assign o_busy           = (state_q != ST_IDLE) | valid_s | pend_q;

endmodule

// File: tb/tb_fifo_stream_out.sv
// Directed bench for fifo_stream_out: behavioural FIFOs feed two instances
// (default framing, and FRAME_LEN=1/CNT_W=2); a scoreboard checks every pop.
module tb_fifo_stream_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a, en_b;
  logic [15:0] cnt_a;
  logic [1:0]  cnt_b;
  logic        busy_a, busy_b;

  fifo_stream_out_if #(.DATA_W(32)) a_if ();
  fifo_stream_out_if #(.DATA_W(32)) b_if ();

  fifo_stream_out #(.DATA_W(32), .FRAME_LEN(4), .CNT_W(16)) dut_a (
    .in_clk(clk), .in_rst(rst), .in_enable(en_a), .s_if(a_if.master),
    .o_frame_cnt(cnt_a), .o_busy(busy_a)
  );

  fifo_stream_out #(.DATA_W(32), .FRAME_LEN(1), .CNT_W(2)) dut_b (
    .in_clk(clk), .in_rst(rst), .in_enable(en_b), .s_if(b_if.master),
    .o_frame_cnt(cnt_b), .o_busy(busy_b)
  );

  // Behavioural FIFOs with one-cycle registered read data
  logic [31:0] mem_a [0:63];
  logic [31:0] mem_b [0:63];
  int unsigned wr_a = 0, rd_a = 0, wr_b = 0, rd_b = 0;

  assign a_if.in_fifo_empty = (rd_a == wr_a);
  assign b_if.in_fifo_empty = (rd_b == wr_b);

  always @(posedge clk) begin
    if (a_if.o_fifo_r_en) begin
      a_if.in_fifo_data <= mem_a[rd_a[5:0]];
      rd_a <= rd_a + 1;
    end
    if (b_if.o_fifo_r_en) begin
      b_if.in_fifo_data <= mem_b[rd_b[5:0]];
      rd_b <= rd_b + 1;
    end
  end

  typedef struct packed {
    logic [31:0] d;
    logic        l;
  } exp_t;

  exp_t sb_a[$];
  exp_t sb_b[$];
  int   idx_a = 0;
  logic [15:0] exp_fr_a = 16'd0;
  logic [1:0]  exp_fr_b = 2'd0;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int reads_a = 0;
  int pops_a = 0;
  int first_rd_a = -1, first_pop_a = -1, last_pop_a = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic put_a(input logic [31:0] v);
    mem_a[wr_a[5:0]] = v;
    wr_a++;
  endtask

  task automatic expect_a(input logic [31:0] v);
    sb_a.push_back({v, (idx_a % 4) == 3});
    idx_a++;
  endtask

  task automatic reset_phase();
    reads_a = 0; pops_a = 0;
    first_rd_a = -1; first_pop_a = -1; last_pop_a = -1;
  endtask

  // One clock: sample at negedge+1 (inputs settled), score pops, advance.
  task automatic step();
    exp_t e;
    #1;
    cyc++;
    check("rd_en_while_empty_a", {63'd0, a_if.o_fifo_r_en & a_if.in_fifo_empty}, 64'd0);
    check("rd_en_while_empty_b", {63'd0, b_if.o_fifo_r_en & b_if.in_fifo_empty}, 64'd0);
    if (a_if.o_fifo_r_en) begin
      reads_a++;
      if (first_rd_a < 0) first_rd_a = cyc;
    end
    if (a_if.o_valid && a_if.in_ready) begin
      check("sb_nonempty_a", {63'd0, sb_a.size() != 0}, 64'd1);
      if (sb_a.size() != 0) begin
        e = sb_a.pop_front();
        check("data_a", 64'(a_if.o_data), 64'(e.d));
        check("last_a", {63'd0, a_if.o_last}, {63'd0, e.l});
        check("frame_cnt_a", 64'(cnt_a), 64'(exp_fr_a));
        if (e.l) exp_fr_a = exp_fr_a + 16'd1;
      end
      pops_a++;
      if (first_pop_a < 0) first_pop_a = cyc;
      last_pop_a = cyc;
    end
    if (b_if.o_valid && b_if.in_ready) begin
      check("sb_nonempty_b", {63'd0, sb_b.size() != 0}, 64'd1);
      if (sb_b.size() != 0) begin
        e = sb_b.pop_front();
        check("data_b", 64'(b_if.o_data), 64'(e.d));
        check("last_b", {63'd0, b_if.o_last}, {63'd0, e.l});
        check("frame_cnt_b", 64'(cnt_b), 64'(exp_fr_b));
        if (e.l) exp_fr_b = exp_fr_b + 2'd1;
      end
    end
    @(negedge clk);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && (sb_a.size() != 0 || sb_b.size() != 0); i++) step();
    check("drain_done_a", 64'(sb_a.size()), 64'd0);
    check("drain_done_b", 64'(sb_b.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; en_a = 1'b0; en_b = 1'b0;
    a_if.in_ready = 1'b0; b_if.in_ready = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rst_valid", {63'd0, a_if.o_valid}, 64'd0);
    check("rst_busy", {63'd0, busy_a}, 64'd0);
    check("rst_cnt", 64'(cnt_a), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Idle with a loaded FIFO: nothing read or output while disabled
    for (int v = 1; v <= 8; v++) begin put_a(32'(v)); expect_a(32'(v)); end
    a_if.in_ready = 1'b1;
    reset_phase();
    repeat (4) step();
    check("idle_reads", 64'(reads_a), 64'd0);
    check("idle_valid", {63'd0, a_if.o_valid}, 64'd0);

    // Streaming 1..8
    en_a = 1'b1;
    drain(40);
    check("stream_latency", 64'(first_pop_a - first_rd_a), 64'd2);
    check("stream_pops", 64'(pops_a), 64'd8);
    check("stream_no_gaps", 64'(last_pop_a - first_pop_a), 64'd7);
    check("stream_frames", 64'(cnt_a), 64'd2);
    en_a = 1'b0;
    repeat (2) step();
    check("stream_idle_busy", {63'd0, busy_a}, 64'd0);

    // Back-pressure: 5..8 with in_ready low for 5 cycles
    a_if.in_ready = 1'b0;
    en_a = 1'b1;
    for (int v = 5; v <= 8; v++) begin put_a(32'(v)); expect_a(32'(v)); end
    reset_phase();
    repeat (5) step();
    check("bp_reads", 64'(reads_a), 64'd2);
    check("bp_valid", {63'd0, a_if.o_valid}, 64'd1);
    check("bp_hold", 64'(a_if.o_data), 64'd5);
    a_if.in_ready = 1'b1;
    reset_phase();
    drain(20);
    check("bp_pops", 64'(pops_a), 64'd4);
    check("bp_no_gaps", 64'(last_pop_a - first_pop_a), 64'd3);
    check("bp_frames", 64'(cnt_a), 64'd3);

    // Stop at boundary: enable drops after the 2nd read of a frame
    for (int v = 9; v <= 14; v++) put_a(32'(v));
    for (int v = 9; v <= 12; v++) expect_a(32'(v));
    reset_phase();
    for (int i = 0; i < 20 && reads_a < 2; i++) step();
    en_a = 1'b0;
    drain(20);
    repeat (3) step();
    check("stop_reads", 64'(reads_a), 64'd4);
    check("stop_busy", {63'd0, busy_a}, 64'd0);
    check("stop_frames", 64'(cnt_a), 64'd4);

    // Empty guard: only words 13,14 remain
    expect_a(32'd13); expect_a(32'd14);
    reset_phase();
    en_a = 1'b1;
    repeat (8) step();
    check("empty_reads", 64'(reads_a), 64'd2);
    check("empty_valid", {63'd0, a_if.o_valid}, 64'd0);
    check("empty_busy_run", {63'd0, busy_a}, 64'd1);
    check("empty_sb", 64'(sb_a.size()), 64'd0);
    en_a = 1'b0;
    repeat (3) step();
    check("empty_busy_stop", {63'd0, busy_a}, 64'd1);

    // Reset mid-stream
    for (int v = 20; v <= 27; v++) begin put_a(32'(v)); expect_a(32'(v)); end
    en_a = 1'b1;
    repeat (5) step();
    check("pre_rst_frames", 64'(cnt_a), 64'd5);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", {63'd0, a_if.o_valid}, 64'd0);
    check("mid_rst_last", {63'd0, a_if.o_last}, 64'd0);
    check("mid_rst_rd_en", {63'd0, a_if.o_fifo_r_en}, 64'd0);
    check("mid_rst_busy", {63'd0, busy_a}, 64'd0);
    check("mid_rst_cnt", 64'(cnt_a), 64'd0);
    sb_a.delete(); idx_a = 0; exp_fr_a = 16'd0;
    en_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_phase();
    repeat (4) step();
    check("post_rst_reads", 64'(reads_a), 64'd0);
    check("post_rst_valid", {63'd0, a_if.o_valid}, 64'd0);

    // Wrap: FRAME_LEN=1, CNT_W=2, 5 words
    for (int v = 0; v < 5; v++) begin
      mem_b[wr_b[5:0]] = 32'hA0 + 32'(v);
      wr_b++;
      sb_b.push_back({32'hA0 + 32'(v), 1'b1});
    end
    en_b = 1'b1;
    drain(30);
    check("wrap_cnt_final", 64'(cnt_b), 64'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
